// File: rtl/ser_to_par_pkg.sv
// Shared types and defaults for the serial-to-parallel receiver.
// Frame layout: alternating preamble starting with 1, then MSB-first bytes.
package ser_to_par_pkg;

    typedef enum logic [2:0] {
        StSync,
        StIdle,
        StPre,
        StData,
        StDrop
    } state_e;

    localparam int unsigned DefPreamble = 6;
    localparam int unsigned DefDataW    = 8;
    localparam int unsigned DefCntW     = 8;

    // Expected preamble bit at position idx: 1 on even positions.
    function automatic logic pre_bit(input int unsigned idx);
        return (idx % 2) == 0;
    endfunction

endpackage

// File: rtl/ser_to_par_preamble_chk.sv
// Preamble checker: tracks the preamble bit position and compares each stepped bit
// against the alternating pattern.
module ser_to_par_preamble_chk
    import ser_to_par_pkg::*;
#(
    parameter int unsigned PREAMBLE = DefPreamble
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic step_i,
    input  logic bit_i,
    output logic done_o,
    output logic mismatch_o
);

    localparam int unsigned IdxW = (PREAMBLE > 1) ? $clog2(PREAMBLE) : 1;

    logic [IdxW-1:0] idx_q, idx_d;
    logic            expected;
    logic            last;

    always_comb begin
        expected   = pre_bit(32'(idx_q));
        last       = (idx_q == IdxW'(PREAMBLE - 1));
        mismatch_o = step_i && (bit_i != expected);
        done_o     = step_i && (bit_i == expected) && last;
        // Any cycle without a step restarts the pattern from position 0.
        if (!step_i || mismatch_o || done_o) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/ser_to_par.sv
// Serial-to-parallel receiver: validates the preamble, deserialises MSB-first bytes
// and reports bytes, clean frame ends, malformed frames and per-frame byte counts.
module ser_to_par
    import ser_to_par_pkg::*;
#(
    parameter int unsigned PREAMBLE = DefPreamble,
    parameter int unsigned DATA_W   = DefDataW,
    parameter int unsigned CNT_W    = DefCntW
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              ser_data_i,
    output logic [DATA_W-1:0] prl_data_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              frame_end_o,
    output logic [CNT_W-1:0]  byte_cnt_o,
    output logic              err_o
);

    localparam int unsigned BitW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] prl_q, prl_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d;
    logic              fe_q, fe_d;
    logic              err_q, err_d;
    logic              pre_step, pre_done, pre_mis;
    logic              last_bit;

    assign pre_step = en_i && ((state_q == StIdle) || (state_q == StPre));
    assign last_bit = (bit_q == BitW'(DATA_W - 1));

    ser_to_par_preamble_chk #(
        .PREAMBLE (PREAMBLE)
    ) u_pre_chk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .step_i     (pre_step),
        .bit_i      (ser_data_i),
        .done_o     (pre_done),
        .mismatch_o (pre_mis)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StSync;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StSync: if (!en_i) state_d = StIdle;
            StIdle, StPre: begin
                if (!en_i) begin
                    state_d = StIdle;
                end else if (pre_mis) begin
                    state_d = StDrop;
                end else if (pre_done) begin
                    state_d = StData;
                end else begin
                    state_d = StPre;
                end
            end
            StData: if (!en_i) state_d = StIdle;
            StDrop: if (!en_i) state_d = StIdle;
            default: state_d = StSync;
        endcase
    end

    always_comb begin
        shift_d = shift_q;
        prl_d   = prl_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        fe_d    = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                bit_d = '0;
                if (en_i) begin
                    cnt_d = '0;
                    err_d = pre_mis;
                end
            end
            StPre: begin
                bit_d = '0;
                err_d = !en_i || pre_mis;
            end
            StData: begin
                if (en_i) begin
                    shift_d = (shift_q << 1) | DATA_W'(ser_data_i);
                    if (last_bit) begin
                        bit_d   = '0;
                        prl_d   = shift_d;
                        valid_d = 1'b1;
                        cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end else begin
                    // Frame closes cleanly only on a byte boundary.
                    bit_d = '0;
                    fe_d  = (bit_q == '0);
                    err_d = (bit_q != '0);
                end
            end
            default: bit_d = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            prl_q   <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            prl_q   <= prl_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            err_q   <= err_d;
        end
    end

    assign prl_data_o  = prl_q;
    assign valid_o     = valid_q;
    assign frame_end_o = fe_q;
    assign err_o       = err_q;
    assign byte_cnt_o  = cnt_q;
    assign busy_o      = (state_q == StPre) || (state_q == StData) || (state_q == StDrop);

endmodule

// File: tb/tb_ser_to_par.sv
// Bench for ser_to_par: per-cycle vector table, hand-written corner sequences and
// randomized frames checked against a frame-level event model.
module tb_ser_to_par;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       en_i = 1'b0;
    logic       ser_data_i = 1'b0;
    logic [7:0] prl_data_o;
    logic       valid_o;
    logic       busy_o;
    logic       frame_end_o;
    logic [7:0] byte_cnt_o;
    logic       err_o;

    ser_to_par #(
        .PREAMBLE (6),
        .DATA_W   (8),
        .CNT_W    (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .ser_data_i  (ser_data_i),
        .prl_data_o  (prl_data_o),
        .valid_o     (valid_o),
        .busy_o      (busy_o),
        .frame_end_o (frame_end_o),
        .byte_cnt_o  (byte_cnt_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       en;
        logic       d;
        logic       v;
        logic [7:0] data;
        logic       fe;
        logic       err;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t        vt[$];
    int          n_vec = 0;
    int          n_bad = 0;
    int          cyc = 0;
    logic [7:0]  exp_b[$], got_b[$], tx_q[$];
    int unsigned exp_c[$], got_c[$];
    int          got_cyc[$];
    int          exp_err = 0;
    int          got_err = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (valid_o) begin
            got_b.push_back(prl_data_o);
            got_cyc.push_back(cyc);
        end
        if (frame_end_o) got_c.push_back(32'(byte_cnt_o));
        if (err_o) got_err = got_err + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(input logic en, input logic d, input logic v,
                                input logic [7:0] data, input logic fe, input logic err,
                                input logic busy, input logic [7:0] cnt);
        vec_t r;
        r.en = en; r.d = d; r.v = v; r.data = data;
        r.fe = fe; r.err = err; r.busy = busy; r.cnt = cnt;
        return r;
    endfunction

    task automatic drive(input logic e, input logic d);
        en_i = e;
        ser_data_i = d;
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_pre();
        for (int i = 0; i < 6; i++) drive(1'b1, (i % 2) == 0);
    endtask

    task automatic drive_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) drive(1'b1, b[i]);
    endtask

    // Model: a clean frame yields each byte in order and one frame end with the
    // saturated byte count.
    task automatic send_frame();
        drive_pre();
        foreach (tx_q[i]) begin
            drive_byte(tx_q[i]);
            exp_b.push_back(tx_q[i]);
        end
        exp_c.push_back((tx_q.size() > 255) ? 255 : tx_q.size());
        drive(1'b0, 1'b0);
    endtask

    task automatic clear_events();
        exp_b.delete(); got_b.delete(); got_cyc.delete();
        exp_c.delete(); got_c.delete();
        exp_err = 0; got_err = 0;
    endtask

    task automatic check_events(input string name);
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        n_vec++;
        if (got_b.size() != exp_b.size()) begin
            n_bad++;
            $display("FAIL %s valid count: got %0d want %0d", name, got_b.size(), exp_b.size());
        end
        for (int i = 0; i < exp_b.size() && i < got_b.size(); i++) begin
            n_vec++;
            if (got_b[i] !== exp_b[i]) begin
                n_bad++;
                $display("FAIL %s byte %0d: got %02h want %02h", name, i, got_b[i], exp_b[i]);
            end
        end
        n_vec++;
        if (got_c.size() != exp_c.size()) begin
            n_bad++;
            $display("FAIL %s frame_end count: got %0d want %0d", name, got_c.size(),
                     exp_c.size());
        end
        for (int i = 0; i < exp_c.size() && i < got_c.size(); i++) begin
            n_vec++;
            if (got_c[i] != exp_c[i]) begin
                n_bad++;
                $display("FAIL %s byte_cnt frame %0d: got %0d want %0d", name, i, got_c[i],
                         exp_c[i]);
            end
        end
        n_vec++;
        if (got_err != exp_err) begin
            n_bad++;
            $display("FAIL %s err pulses: got %0d want %0d", name, got_err, exp_err);
        end
        clear_events();
    endtask

    task automatic check_zero(input string name);
        n_vec++;
        if ({valid_o, prl_data_o, frame_end_o, err_o, busy_o, byte_cnt_o} !== 20'h0) begin
            n_bad++;
            $display("FAIL %s: got v=%b d=%02h fe=%b err=%b busy=%b cnt=%0d want all 0", name,
                     valid_o, prl_data_o, frame_end_o, err_o, busy_o, byte_cnt_o);
        end
    endtask

    initial begin
        logic [7:0] a9;
        logic [7:0] b9;
        logic [7:0] b2;
        logic [19:0] got;
        logic [19:0] exp;
        int sent;
        int n;
        a9 = 8'hA9;
        b9 = 8'hB9;

        // Frame 101010 + A9.
        vt.push_back(mk(0, 0, 0, 8'h00, 0, 0, 0, 0));
        for (int i = 0; i < 6; i++) vt.push_back(mk(1, (i % 2) == 0, 0, 8'h00, 0, 0, 1, 0));
        for (int i = 7; i >= 1; i--) vt.push_back(mk(1, a9[i], 0, 8'h00, 0, 0, 1, 0));
        vt.push_back(mk(1, a9[0], 1, 8'hA9, 0, 0, 1, 1));
        vt.push_back(mk(0, 0, 0, 8'hA9, 1, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 8'hA9, 0, 0, 0, 1));
        // Bad preamble 100010 + B9: error on the third bit, then dropped.
        vt.push_back(mk(1, 1, 0, 8'hA9, 0, 0, 1, 0));
        vt.push_back(mk(1, 0, 0, 8'hA9, 0, 0, 1, 0));
        vt.push_back(mk(1, 0, 0, 8'hA9, 0, 1, 1, 0));
        vt.push_back(mk(1, 0, 0, 8'hA9, 0, 0, 1, 0));
        vt.push_back(mk(1, 1, 0, 8'hA9, 0, 0, 1, 0));
        vt.push_back(mk(1, 0, 0, 8'hA9, 0, 0, 1, 0));
        for (int i = 7; i >= 0; i--) vt.push_back(mk(1, b9[i], 0, 8'hA9, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 8'hA9, 0, 0, 0, 0));
        // Good preamble, 4 data bits, then en_i low: partial byte error.
        for (int i = 0; i < 6; i++) vt.push_back(mk(1, (i % 2) == 0, 0, 8'hA9, 0, 0, 1, 0));
        for (int i = 0; i < 4; i++) vt.push_back(mk(1, i < 2, 0, 8'hA9, 0, 0, 1, 0));
        vt.push_back(mk(0, 0, 0, 8'hA9, 0, 1, 0, 0));
        vt.push_back(mk(0, 0, 0, 8'hA9, 0, 0, 0, 0));

        repeat (3) drive(1'b0, 1'b0);
        check_zero("reset");
        rst_i = 1'b0;

        foreach (vt[i]) begin
            drive(vt[i].en, vt[i].d);
            got = {valid_o, prl_data_o, frame_end_o, err_o, busy_o, byte_cnt_o};
            exp = {vt[i].v, vt[i].data, vt[i].fe, vt[i].err, vt[i].busy, vt[i].cnt};
            n_vec++;
            if (got !== exp) begin
                n_bad++;
                $display("FAIL vec%0d: got v=%b d=%02h fe=%b err=%b busy=%b cnt=%0d want v=%b d=%02h fe=%b err=%b busy=%b cnt=%0d",
                         i, got[19], got[18:11], got[10], got[9], got[8], got[7:0],
                         exp[19], exp[18:11], exp[10], exp[9], exp[8], exp[7:0]);
            end
        end
        clear_events();

        // Back-to-back bytes arrive exactly 8 cycles apart.
        tx_q = '{8'hBA, 8'hA2, 8'hE3, 8'hAA, 8'hBF};
        send_frame();
        drive(1'b0, 1'b0);
        for (int i = 1; i < got_cyc.size(); i++) begin
            n_vec++;
            if (got_cyc[i] - got_cyc[i-1] != 8) begin
                n_bad++;
                $display("FAIL spacing %0d: got %0d cycles want 8", i, got_cyc[i] - got_cyc[i-1]);
            end
        end
        check_events("b2b");

        // Reset during the second byte of a three-byte frame.
        b2 = 8'h22;
        drive_pre();
        drive_byte(8'h11);
        for (int i = 7; i >= 5; i--) drive(1'b1, b2[i]);
        rst_i = 1'b1;
        drive(1'b1, b2[4]);
        rst_i = 1'b0;
        check_zero("rst_mid");
        clear_events();
        for (int i = 3; i >= 0; i--) drive(1'b1, b2[i]);
        drive_byte(8'h33);
        drive(1'b0, 1'b0);
        tx_q = '{8'h5C};
        send_frame();
        check_events("rst_mid_frame");

        // Byte counter saturation.
        tx_q.delete();
        for (int i = 0; i < 260; i++) tx_q.push_back(8'($urandom));
        send_frame();
        check_events("saturate");

        // Random frames, some ending on a partial byte.
        sent = 0;
        while (sent < 100) begin
            n = $urandom_range(1, 8);
            if (sent + n > 100) n = 100 - sent;
            drive_pre();
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                drive_byte(b);
                exp_b.push_back(b);
            end
            sent += n;
            if ($urandom_range(0, 4) == 0) begin
                repeat ($urandom_range(1, 7)) drive(1'b1, 1'($urandom_range(0, 1)));
                exp_err++;
            end else begin
                exp_c.push_back(n);
            end
            repeat ($urandom_range(1, 3)) drive(1'b0, 1'b0);
        end
        check_events("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
